// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, operation encoding and a count-width helper.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 8;

    // {write_accept, read_accept} for one clock edge
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_sync_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  i_clock,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock parametrised FIFO with threshold flags, occupancy count and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through read mode; default is registered read.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH               = DEFAULT_DEPTH,
    parameter int unsigned ALMOST_FULL_THRESH  = 6,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    write_enable,
    input  logic                    read_enable,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH  = count_width(DEPTH);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(ALMOST_FULL_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(ALMOST_EMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_read_accept;
    logic                  w_write_accept;
    logic [CNT_WIDTH-1:0]  w_count_next;
    logic [DATA_WIDTH-1:0] w_rd_data;
    fifo_op_e              w_op;

    // Flags decode the registered count only, so no enable-to-flag path exists.
    assign fifo_full    = (r_count == FULL_CNT);
    assign fifo_empty   = (r_count == '0);
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_read_accept  = read_enable && !fifo_empty;
    assign w_write_accept = write_enable && (!fifo_full || w_read_accept);
    assign w_op           = fifo_op_e'({w_write_accept, w_read_accept});

    always_comb begin
        w_count_next = r_count;
        case (w_op)
            OP_WRITE: w_count_next = r_count + CNT_WIDTH'(1);
            OP_READ:  w_count_next = r_count - CNT_WIDTH'(1);
            default:  w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_write_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_read_accept) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count     <= w_count_next;
            r_overflow  <= r_overflow  | (write_enable && !w_write_accept);
            r_underflow <= r_underflow | (read_enable  && !w_read_accept);
        end
    end

    fifo_sync_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clock   (clock),
        .i_wr_en   (w_write_accept && !reset),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

`ifdef FIFO_SYNC_FWFT_EN
    assign q = w_rd_data;
`else
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (w_read_accept) begin
            r_q <= w_rd_data;
        end
    end

    assign q = r_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: vector table, corner-case sequences and random traffic vs a queue model.
module tb_fifo_sync;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int AET   = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] data;
    logic          write_enable;
    logic          read_enable;
    logic [DW-1:0] q;
    logic          fifo_full, fifo_empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    fifo_sync #(
        .DATA_WIDTH          (DW),
        .DEPTH               (DEPTH),
        .ALMOST_FULL_THRESH  (AFT),
        .ALMOST_EMPTY_THRESH (AET)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data         (data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .q            (q),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: a plain queue plus sticky bits and the last popped word.
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_q;
    logic [DW-1:0] last_pop;

    typedef struct {
        bit            we;
        bit            re;
        logic [DW-1:0] d;
        int            cnt;
        bit            full, empty, af, ae, ovf, unf;
        logic [DW-1:0] q;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count",        32'(count),        32'(mq.size()));
        chk("fifo_full",    32'(fifo_full),    32'(mq.size() == DEPTH));
        chk("fifo_empty",   32'(fifo_empty),   32'(mq.size() == 0));
        chk("almost_full",  32'(almost_full),  32'(mq.size() >= AFT));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AET));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
`ifdef FIFO_SYNC_FWFT_EN
        if (mq.size() > 0) chk("q_head", q, mq[0]);
`else
        chk("q", q, m_q);
`endif
    endtask

    task automatic step(input bit we, input bit re, input logic [DW-1:0] d);
        bit ra, wa;
        write_enable = we;
        read_enable  = re;
        data         = d;
        @(posedge clock);
        #1;
        ra = re && (mq.size() > 0);
        wa = we && ((mq.size() < DEPTH) || ra);
        if (ra) begin
            last_pop = mq.pop_front();
            m_q      = last_pop;
        end
        if (wa) mq.push_back(d);
        if (we && !wa) m_ovf = 1'b1;
        if (re && !ra) m_unf = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check_model();
    endtask

    task automatic do_reset(input bit we, input logic [DW-1:0] d);
        reset        = 1'b1;
        write_enable = we;
        read_enable  = 1'b0;
        data         = d;
        @(posedge clock);
        #1;
        reset        = 1'b0;
        write_enable = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_q   = '0;
        check_model();
    endtask

    function automatic void add(input bit we, input bit re, input logic [DW-1:0] d, input int cnt,
                                input bit full, input bit empty, input bit af, input bit ae,
                                input bit ovf, input bit unf, input logic [DW-1:0] qv);
        vec_t v;
        v.we = we; v.re = re; v.d = d; v.cnt = cnt;
        v.full = full; v.empty = empty; v.af = af; v.ae = ae;
        v.ovf = ovf; v.unf = unf; v.q = qv;
        tbl.push_back(v);
    endfunction

    initial begin
        reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0; data = '0;
        mq.delete(); m_ovf = 0; m_unf = 0; m_q = '0; last_pop = '0;
        @(posedge clock);
        #1;

        //   we re  d   cnt full empty af ae ovf unf q
        add(1, 0,  2,  1, 0, 0, 0, 1, 0, 0,  0);
        add(0, 1,  0,  0, 0, 1, 0, 1, 0, 0,  2);
        add(1, 0,  3,  1, 0, 0, 0, 1, 0, 0,  2);
        add(1, 0,  4,  2, 0, 0, 0, 1, 0, 0,  2);
        add(1, 0,  5,  3, 0, 0, 0, 0, 0, 0,  2);
        add(1, 0,  6,  4, 0, 0, 0, 0, 0, 0,  2);
        add(1, 0,  7,  5, 0, 0, 0, 0, 0, 0,  2);
        add(1, 0,  8,  6, 0, 0, 1, 0, 0, 0,  2);
        add(1, 0,  9,  7, 0, 0, 1, 0, 0, 0,  2);
        add(1, 0, 10,  8, 1, 0, 1, 0, 0, 0,  2);
        add(1, 0, 11,  8, 1, 0, 1, 0, 1, 0,  2);
        add(0, 1,  0,  7, 0, 0, 1, 0, 1, 0,  3);
        add(0, 1,  0,  6, 0, 0, 1, 0, 1, 0,  4);
        add(0, 1,  0,  5, 0, 0, 0, 0, 1, 0,  5);
        add(0, 1,  0,  4, 0, 0, 0, 0, 1, 0,  6);
        add(0, 1,  0,  3, 0, 0, 0, 0, 1, 0,  7);
        add(0, 1,  0,  2, 0, 0, 0, 1, 1, 0,  8);
        add(0, 1,  0,  1, 0, 0, 0, 1, 1, 0,  9);
        add(0, 1,  0,  0, 0, 1, 0, 1, 1, 0, 10);
        add(0, 1,  0,  0, 0, 1, 0, 1, 1, 1, 10);

        do_reset(1'b0, '0);
        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].re, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), 32'(count),     32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full",  i), 32'(fifo_full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(fifo_empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_af",    i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d_ae",    i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d_ovf",   i), 32'(overflow),  32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf",   i), 32'(underflow), 32'(tbl[i].unf));
`ifndef FIFO_SYNC_FWFT_EN
            chk($sformatf("tbl%0d_q",     i), q, tbl[i].q);
`else
            if (i == 0) chk("tbl0_fwft_q", q, 32'd2);
`endif
        end

        // Full FIFO with simultaneous write and read.
        do_reset(1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 32'(200 + i));
        step(1, 1, 99);
        chk("full_rw_count", 32'(count), 32'd8);
        chk("full_rw_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0);
        chk("full_rw_last99", last_pop, 32'd99);
        chk("full_rw_noovf", 32'(overflow), 32'd0);

        // Empty FIFO with simultaneous write and read.
        do_reset(1'b0, '0);
        step(1, 1, 5);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
`ifdef FIFO_SYNC_FWFT_EN
        chk("empty_rw_fwft_q", q, 32'd5);
`endif
        step(0, 1, '0);
`ifndef FIFO_SYNC_FWFT_EN
        chk("empty_rw_q5", q, 32'd5);
`endif

        // Wrap-around traffic then reset mid-stream with a write pending.
        do_reset(1'b0, '0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 32'(100 + i));
            if (i % 2 == 1) step(0, 1, '0);
        end
        step(1, 1, 77);
        do_reset(1'b1, 32'h55);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        step(1, 0, 7);
`ifdef FIFO_SYNC_FWFT_EN
        chk("rst_fwft_q7", q, 32'd7);
`endif
        step(0, 1, '0);
`ifndef FIFO_SYNC_FWFT_EN
        chk("rst_q7", q, 32'd7);
`endif
        chk("rst_empty_again", 32'(fifo_empty), 32'd1);

        // Random traffic with shifting write/read bias and rare resets.
        do_reset(1'b0, '0);
        for (int i = 0; i < 1500; i++) begin
            int wp, rp;
            wp = ((i / 150) % 2 == 0) ? 65 : 35;
            rp = 100 - wp;
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1'($urandom_range(0, 1)), $urandom);
            end else begin
                step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, parametrised FIFO; successor to the dual-clock 32-bit `fifo`, for producer/consumer pairs in one clock domain. Adds configurable width, depth and almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. An optional first-word-fall-through read mode is selected at compile time.

## Interface
- `DATA_WIDTH`, 32, word width in bits.
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `ALMOST_FULL_THRESH`, 6, `almost_full` asserts when count ≥ this; range 1..DEPTH.
- `ALMOST_EMPTY_THRESH`, 2, `almost_empty` asserts when count ≤ this; range 0..DEPTH-1.
- Derived localparam `ADDR_WIDTH` = clog2(DEPTH).

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `data`  in  DATA_WIDTH  write data.
- `write_enable`  in  1  write request.
- `read_enable`  in  1  read request (pop).
- `q`  out  DATA_WIDTH  read data.
- `fifo_full`  out  1  count == DEPTH.
- `fifo_empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ ALMOST_FULL_THRESH.
- `almost_empty`  out  1  count ≤ ALMOST_EMPTY_THRESH.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was refused.
- `underflow`  out  1  sticky: a read was refused.

## Operation
- Read accept: `read_enable && !fifo_empty`.
- Write accept: `write_enable && (!fifo_full || read_accept)`. When full, a write is accepted only if a read is accepted in the same cycle.
- Both accepted in one cycle: `count` is unchanged and both pointers advance.
- When empty, a simultaneous read is refused (`underflow` sets) and the write is accepted (count goes 0→1).
- Pointers are ADDR_WIDTH bits wide and wrap from DEPTH-1 to 0 naturally. The write stores `data` at `wr_ptr`.
- `count` updates as +1 on write-only, -1 on read-only, and 0 otherwise. It never exceeds DEPTH and never goes below 0.
- `overflow` sets on `write_enable && !write_accept`. `underflow` sets on `read_enable && !read_accept`. Both clear only on reset.
- All flags are decoded from registered `count`, so they carry no combinational path from the enables.
- Reset values:
  - Zero: pointers, `count`, `q`, `fifo_full`, `almost_full`, `overflow`, `underflow`.
  - One: `fifo_empty`, `almost_empty`.
  - Memory contents are not cleared.
- Reset applied mid-operation discards all stored words. The first read after reset sees only post-reset writes.

## Timing
- Write latency: a word written at edge N is readable from edge N+1; `fifo_empty` deasserts after edge N.
- Flags and `count` reflect accepts of the preceding edge; they are valid one cycle after the accept.
- Standard mode: `q` is a register loaded with `mem[rd_ptr]` on an accepted read edge and is valid after that edge (1-cycle latency). Otherwise `q` holds its previous value.
- Refused operations change nothing except the sticky flags.

## Configuration
- `FIFO_SYNC_FWFT_EN` defined: first-word fall-through. `q` is driven continuously from `mem[rd_ptr]` and shows the head word whenever `!fifo_empty`. `read_enable` acknowledges and pops the head. A write to an empty FIFO at edge N shows on `q` after edge N. `q` is don't-care while empty.
- Undefined: standard registered-read mode as in Timing.
- Flags, count, accept rules and error flags are identical in both modes.

## Structure
- Package `fifo_pkg`: default width/depth constants and a count-width helper (`clog2`+1), shared with future FIFO variants.
- Sub-module `fifo_sync_mem`: DEPTH×DATA_WIDTH storage with one synchronous write port and one asynchronous read port. The top level owns pointers, count, flags and the `q` register.

## Test plan
All scenarios use DEPTH=8, ALMOST_FULL_THRESH=6, ALMOST_EMPTY_THRESH=2.
- Reset, then write 2 and read once → `q`=2 one edge after the read accept (FWFT: `q`=2 right after the write); `fifo_empty` returns to 1.
- Write 3..10 (8 words) → `count`=8 and `fifo_full`=1; `almost_full` rose at count 6 and `almost_empty` fell at count 3. Extra write of 11 → `overflow`=1 and `count` stays 8.
- Drain all 8 → reads return 3..10 in order; a 9th read → `underflow`=1 with `q` unchanged.
- Fill to full, then assert write of 99 and read together → `count` stays 8 and the head is popped. After draining, 99 is last; no `overflow`.
- Empty FIFO with simultaneous write of 5 and read → `count`=1 and `underflow`=1; the next read returns 5.
- Write 12 words with reads interleaved for wrap-around, assert `reset` mid-stream, then write 7 and read → `q`=7; `count`, `overflow` and `underflow` are all 0 after reset.
